// File: rtl/writeback_trap_unit.sv
// writeback_trap_unit: retire-time interrupt trap/return controller with one-cycle fetch redirect
module writeback_trap_unit #(
  parameter int NUM_IRQ    = 2,
  parameter int XLEN       = 32,
  parameter int VECTORED   = 0,
  parameter int CAUSE_BASE = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_IRQ-1:0]  irq_in,
  input  logic [NUM_IRQ-1:0]  irq_mask_in,
  input  logic                irq_enable_in,
  input  logic                retire_valid_in,
  input  logic                mret_in,
  input  logic [XLEN-1:0]     next_pc_in,
  input  logic [XLEN-1:0]     trap_vector_in,
  output logic                redirect_out,
  output logic [XLEN-1:0]     jump_address_out,
  output logic                flush_out,
  output logic [NUM_IRQ-1:0]  irq_ack_out,
  output logic [XLEN-1:0]     epc_out,
  output logic [XLEN-1:0]     cause_out,
  output logic                in_handler_out
);
  localparam int IW = NUM_IRQ > 1 ? $clog2(NUM_IRQ) : 1;
  typedef enum logic [1:0] {S_RUN, S_TAKE, S_HANDLER, S_RETURN} state_t;
  state_t state, state_n;
  logic [NUM_IRQ-1:0] pending, eligible;
  logic [IW-1:0] win, win_q;
  logic [XLEN-1:0] epc, cause, target, base, code;
  logic take;
  assign eligible = pending & irq_mask_in;
  assign take = state == S_RUN && retire_valid_in && irq_enable_in && !mret_in && |eligible;
  assign base = trap_vector_in & ~XLEN'(3);
  assign code = XLEN'(CAUSE_BASE) + XLEN'(win);
  always_comb begin
    win = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (eligible[i]) win = IW'(i);
  end
  always_ff @(posedge clk) begin
    if (rst) state <= S_RUN;
    else state <= state_n;
  end
  always_comb begin
    state_n = (state == S_RUN)     ? (take ? S_TAKE : S_RUN) :
              (state == S_TAKE)    ? S_HANDLER :
              (state == S_HANDLER) ? ((retire_valid_in && mret_in) ? S_RETURN : S_HANDLER) :
                                     S_RUN;
  end
  // The jump target is resolved at the trap decision so outputs depend only on registered state.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      epc     <= '0;
      cause   <= '0;
      win_q   <= '0;
      target  <= '0;
    end else begin
      pending <= (pending & ~irq_ack_out) | irq_in;
      if (take) begin
        epc    <= next_pc_in;
        cause  <= code | {1'b1, {(XLEN-1){1'b0}}};
        win_q  <= win;
        target <= (VECTORED != 0) ? base + (code << 2) : base;
      end
    end
  end
  always_comb begin
    redirect_out     = state == S_TAKE || state == S_RETURN;
    flush_out        = redirect_out;
    jump_address_out = (state == S_TAKE) ? target : (state == S_RETURN) ? epc : '0;
    irq_ack_out      = (state == S_TAKE) ? NUM_IRQ'(1) << win_q : '0;
    in_handler_out   = state == S_TAKE || state == S_HANDLER;
    epc_out          = epc;
    cause_out        = cause;
  end
endmodule

// File: tb/tb_writeback_trap_unit.sv
// tb_writeback_trap_unit: directed scenario tests for direct and vectored trap units
module tb_writeback_trap_unit;
  logic clk = 0, rst = 0;
  logic [1:0] irq_in = 0, irq_mask_in = 0;
  logic irq_enable_in = 0, retire_valid_in = 0, mret_in = 0;
  logic [31:0] next_pc_in = 0, trap_vector_in = 32'h100;
  logic redirect0, flush0, inh0, redirect1, flush1, inh1;
  logic [31:0] jump0, epc0, cause0, jump1, epc1, cause1;
  logic [1:0] ack0, ack1;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  writeback_trap_unit dut0 (
    .clk(clk), .rst(rst), .irq_in(irq_in), .irq_mask_in(irq_mask_in),
    .irq_enable_in(irq_enable_in), .retire_valid_in(retire_valid_in), .mret_in(mret_in),
    .next_pc_in(next_pc_in), .trap_vector_in(trap_vector_in),
    .redirect_out(redirect0), .jump_address_out(jump0), .flush_out(flush0),
    .irq_ack_out(ack0), .epc_out(epc0), .cause_out(cause0), .in_handler_out(inh0)
  );

  writeback_trap_unit #(.VECTORED(1)) dut1 (
    .clk(clk), .rst(rst), .irq_in(irq_in), .irq_mask_in(irq_mask_in),
    .irq_enable_in(irq_enable_in), .retire_valid_in(retire_valid_in), .mret_in(mret_in),
    .next_pc_in(next_pc_in), .trap_vector_in(trap_vector_in),
    .redirect_out(redirect1), .jump_address_out(jump1), .flush_out(flush1),
    .irq_ack_out(ack1), .epc_out(epc1), .cause_out(cause1), .in_handler_out(inh1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic leave_handler();
    irq_in = 0; retire_valid_in = 0; mret_in = 0;
    tick();
    retire_valid_in = 1; mret_in = 1;
    tick();
    retire_valid_in = 0; mret_in = 0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1;
    tick(); tick();
    total++; if ({redirect0, flush0, inh0, ack0} !== 5'b0) begin bad++; $display("FAIL reset_ctl got=%b exp=0", {redirect0, flush0, inh0, ack0}); end
    total++; if ({jump0, epc0, cause0} !== 96'b0) begin bad++; $display("FAIL reset_data got=%h exp=0", {jump0, epc0, cause0}); end
    rst = 0;
  endtask

  task automatic test_direct_trap();
    irq_mask_in = 2'b11; irq_enable_in = 1; next_pc_in = 32'h2004;
    irq_in = 2'b01;
    tick();
    total++; if (redirect0 !== 1'b0) begin bad++; $display("FAIL no_retire_no_trap got=%b exp=0", redirect0); end
    retire_valid_in = 1;
    tick();
    total++; if ({redirect0, flush0, inh0} !== 3'b111) begin bad++; $display("FAIL take_ctl got=%b exp=111", {redirect0, flush0, inh0}); end
    total++; if (jump0 !== 32'h100) begin bad++; $display("FAIL take_jump got=%h exp=00000100", jump0); end
    total++; if (ack0 !== 2'b01) begin bad++; $display("FAIL take_ack got=%b exp=01", ack0); end
    total++; if (epc0 !== 32'h2004) begin bad++; $display("FAIL take_epc got=%h exp=00002004", epc0); end
    total++; if (cause0 !== 32'h80000007) begin bad++; $display("FAIL take_cause got=%h exp=80000007", cause0); end
    irq_in = 0; retire_valid_in = 0;
    tick();
    total++; if ({redirect0, inh0, ack0} !== 4'b0100) begin bad++; $display("FAIL handler got=%b exp=0100", {redirect0, inh0, ack0}); end
    retire_valid_in = 1; mret_in = 1;
    tick();
    total++; if ({redirect0, flush0, inh0, ack0} !== 5'b11000) begin bad++; $display("FAIL return_ctl got=%b exp=11000", {redirect0, flush0, inh0, ack0}); end
    total++; if (jump0 !== 32'h2004) begin bad++; $display("FAIL return_jump got=%h exp=00002004", jump0); end
    mret_in = 0;
    tick();
    total++; if ({redirect0, jump0} !== 33'b0) begin bad++; $display("FAIL run_after_return got=%h exp=0", {redirect0, jump0}); end
    tick();
    total++; if (redirect0 !== 1'b0) begin bad++; $display("FAIL ack_cleared_pending got=%b exp=0", redirect0); end
    total++; if (cause0 !== 32'h80000007 || epc0 !== 32'h2004) begin bad++; $display("FAIL epc_cause_hold got=%h/%h exp=00002004/80000007", epc0, cause0); end
    retire_valid_in = 0;
  endtask

  task automatic test_vectored();
    irq_in = 2'b11; next_pc_in = 32'h2004;
    tick();
    retire_valid_in = 1;
    tick();
    total++; if (jump1 !== 32'h11C) begin bad++; $display("FAIL vec_jump0 got=%h exp=0000011c", jump1); end
    total++; if (jump0 !== 32'h100) begin bad++; $display("FAIL direct_jump0 got=%h exp=00000100", jump0); end
    total++; if (ack1 !== 2'b01 || cause1 !== 32'h80000007) begin bad++; $display("FAIL vec_win0 got=%b/%h exp=01/80000007", ack1, cause1); end
    irq_in = 2'b10; retire_valid_in = 0; next_pc_in = 32'h3000;
    tick();
    retire_valid_in = 1; mret_in = 1;
    tick();
    total++; if (redirect1 !== 1'b1 || jump1 !== 32'h2004) begin bad++; $display("FAIL vec_return got=%b/%h exp=1/00002004", redirect1, jump1); end
    mret_in = 0;
    tick();
    total++; if (redirect1 !== 1'b0) begin bad++; $display("FAIL no_take_in_return got=%b exp=0", redirect1); end
    tick();
    total++; if (jump1 !== 32'h120 || cause1 !== 32'h80000008 || ack1 !== 2'b10) begin bad++; $display("FAIL vec_win1 got=%h/%h/%b exp=00000120/80000008/10", jump1, cause1, ack1); end
    total++; if (epc1 !== 32'h3000) begin bad++; $display("FAIL vec_epc1 got=%h exp=00003000", epc1); end
    leave_handler();
  endtask

  task automatic test_masking();
    irq_in = 2'b01;
    tick();
    irq_in = 0; irq_mask_in = 2'b00; retire_valid_in = 1;
    tick();
    total++; if (redirect0 !== 1'b0) begin bad++; $display("FAIL masked got=%b exp=0", redirect0); end
    irq_mask_in = 2'b11; irq_enable_in = 0;
    tick();
    total++; if (redirect0 !== 1'b0) begin bad++; $display("FAIL disabled got=%b exp=0", redirect0); end
    irq_enable_in = 1; mret_in = 1;
    tick();
    total++; if (redirect0 !== 1'b0) begin bad++; $display("FAIL mret_in_run got=%b exp=0", redirect0); end
    mret_in = 0; irq_mask_in = 2'b01;
    tick();
    total++; if (redirect0 !== 1'b1 || ack0 !== 2'b01) begin bad++; $display("FAIL unmasked_take got=%b/%b exp=1/01", redirect0, ack0); end
    irq_mask_in = 2'b11;
    leave_handler();
  endtask

  task automatic test_handler();
    irq_in = 2'b01;
    tick();
    retire_valid_in = 1;
    tick();
    irq_in = 0; retire_valid_in = 0;
    tick();
    irq_in = 2'b10; retire_valid_in = 1;
    tick();
    total++; if ({redirect0, ack0, inh0} !== 4'b0001) begin bad++; $display("FAIL no_nesting got=%b exp=0001", {redirect0, ack0, inh0}); end
    irq_in = 0;
    tick();
    total++; if ({redirect0, inh0} !== 2'b01) begin bad++; $display("FAIL still_handler got=%b exp=01", {redirect0, inh0}); end
    mret_in = 1;
    tick();
    total++; if (redirect0 !== 1'b1 || jump0 !== epc0) begin bad++; $display("FAIL handler_return got=%b/%h exp=1/%h", redirect0, jump0, epc0); end
    mret_in = 0; retire_valid_in = 0;
    tick();
    total++; if (redirect0 !== 1'b0) begin bad++; $display("FAIL single_return got=%b exp=0", redirect0); end
  endtask

  task automatic test_reset_abort();
    irq_in = 2'b01;
    tick();
    retire_valid_in = 1;
    tick();
    total++; if (redirect0 !== 1'b1) begin bad++; $display("FAIL abort_setup got=%b exp=1", redirect0); end
    rst = 1; irq_in = 0; retire_valid_in = 0;
    tick();
    total++; if ({redirect0, flush0, inh0, ack0} !== 5'b0 || {jump0, epc0, cause0} !== 96'b0) begin bad++; $display("FAIL abort_outputs got=%b/%h exp=0", {redirect0, flush0, inh0, ack0}, {jump0, epc0, cause0}); end
    rst = 0; retire_valid_in = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++; if (redirect0 !== 1'b0 || inh0 !== 1'b0) begin bad++; $display("FAIL abort_no_redirect[%0d] got=%b/%b exp=0/0", k, redirect0, inh0); end
    end
    retire_valid_in = 0;
  endtask

  initial begin
    test_reset();
    test_direct_trap();
    test_vectored();
    test_masking();
    test_handler();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/writeback_trap_unit.md
WRITEBACK_TRAP_UNIT -- requirements
Module: writeback_trap_unit

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 2, number of interrupt sources, legal range 1..16.
REQ-002 SHALL have parameter XLEN, default 32, address and data width.
REQ-003 SHALL have parameter VECTORED, default 0; 0 selects direct vectoring, 1 selects vectored mode.
REQ-004 SHALL have parameter CAUSE_BASE, default 7, cause code of source 0; source i uses CAUSE_BASE+i.
REQ-005 SHALL have ports, in order:
  clk  in  1  clock; all state updates on its rising edge
  rst  in  1  synchronous reset, active-high
  irq_in  in  NUM_IRQ  level interrupt requests
  irq_mask_in  in  NUM_IRQ  per-source enable, 1 = enabled
  irq_enable_in  in  1  global interrupt enable
  retire_valid_in  in  1  instruction retiring in writeback this cycle
  mret_in  in  1  retiring instruction is a return-from-trap; qualified by retire_valid_in
  next_pc_in  in  XLEN  next program counter of the retiring instruction
  trap_vector_in  in  XLEN  handler base address, bits[1:0] ignored
  redirect_out  out  1  one-cycle jump request to fetch
  jump_address_out  out  XLEN  target while redirect_out=1, else 0
  flush_out  out  1  squash younger pipeline stages; equals redirect_out
  irq_ack_out  out  NUM_IRQ  one-hot acknowledge of the taken source
  epc_out  out  XLEN  saved return address
  cause_out  out  XLEN  saved cause; MSB=1, low bits = CAUSE_BASE+i
  in_handler_out  out  1  1 while in TAKE or HANDLER

Function
REQ-006 SHALL hold a pending register: pending_next = (pending & ~irq_ack_out) | irq_in, evaluated every cycle.
REQ-007 SHALL define eligible = pending & irq_mask_in; the winner SHALL be the lowest-index eligible bit.
REQ-008 SHALL implement the FSM states RUN, TAKE, HANDLER, and RETURN.
REQ-009 RUN: when retire_valid_in=1, irq_enable_in=1, mret_in=0, and eligible!=0, the block SHALL latch epc=next_pc_in, latch the cause of the winner, latch the winner index, and go to TAKE; otherwise it SHALL stay in RUN.
REQ-010 RUN: mret_in SHALL be ignored.
REQ-011 RUN: a trap SHALL never be taken on a cycle with retire_valid_in=0.
REQ-012 TAKE: lasts exactly one cycle, then goes to HANDLER. During TAKE:
  - redirect_out=1 and flush_out=1
  - irq_ack_out = one-hot of the latched winner
  - jump_address_out = {trap_vector_in[XLEN-1:2],2'b00} if VECTORED=0
  - jump_address_out = that base + 4*(CAUSE_BASE+i) if VECTORED=1, modulo 2^XLEN
REQ-013 HANDLER: no interrupt SHALL be taken (no nesting); pending bits keep accumulating.
REQ-014 HANDLER: retire_valid_in=1 with mret_in=1 SHALL move the FSM to RETURN.
REQ-015 RETURN: lasts one cycle, then goes to RUN. During RETURN: redirect_out=1, flush_out=1, jump_address_out=epc, irq_ack_out=0.
REQ-016 Trap latency SHALL be one cycle: the qualifying retire in cycle N gives redirect_out in cycle N+1. The same one-cycle latency SHALL apply to mret.
REQ-017 Mret retiring in HANDLER while eligible!=0 SHALL be handled as a return; the interrupt SHALL be taken at the first qualifying retire in RUN, no earlier than 2 cycles after the RETURN cycle.
REQ-018 An acked source still high SHALL re-set its pending bit in the next cycle; clearing the request is the source's responsibility.
REQ-019 epc_out and cause_out SHALL hold their values until the next TAKE.
REQ-020 Inputs arriving during TAKE or RETURN SHALL be ignored, except for pending updates.
REQ-021 All outputs SHALL be driven from registered state plus combinational decode of the FSM state only, with no input-to-output combinational path.

Reset
REQ-022 rst=1 at a rising edge SHALL set the state to RUN and clear pending, epc, cause, and the winner index.
REQ-023 During and after reset, all outputs SHALL be 0 until the next trap.
REQ-024 rst SHALL override every other input in the same cycle.
REQ-025 Reset asserted in TAKE, HANDLER, or RETURN SHALL abort the operation; no redirect SHALL follow.

Verification
REQ-026 NUM_IRQ=2, VECTORED=0, vector=0x100:
  - stimulus: irq_in=01, mask=11, enable=1, retire with next_pc=0x2004
  - response: next cycle redirect=1, jump=0x100, ack=01, epc=0x2004, cause=0x80000007
REQ-027 VECTORED=1, CAUSE_BASE=7, vector=0x100:
  - stimulus: irq_in=11 simultaneously
  - response: source 0 wins, jump=0x11C
  - stimulus: source 1 stays high; HANDLER mret
  - response: RETURN jump=0x2004, then source 1 taken at the next retire, jump=0x120, cause=0x80000008
REQ-028 Masking and gating:
  - stimulus: mask=00 or enable=0, irq pending, retire
  - response: no redirect; pending stays set
  - stimulus: then mask=01
  - response: trap at the next retire
REQ-029 In HANDLER:
  - stimulus: new irq_in plus retire with mret_in=0
  - response: no redirect, no ack
  - stimulus: retire with mret_in=1
  - response: exactly one RETURN redirect
REQ-030 Reset abort:
  - stimulus: rst in the TAKE cycle
  - response: next cycle all outputs 0, state RUN, pending cleared
  - stimulus: held retire with no irq
  - response: no redirect
